// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline sequencing logic.
// Holds the hazard FSM encoding, the forward-select codes and the select helper.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_MDU_BUSY = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALTED   = 3'd4
    } hc_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // The younger result (EX/MEM) always wins over the older one (MEM/WB).
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of pipeline status inputs and control outputs exchanged with the hazard controller.
// master = pipeline side, slave = hazard controller.
interface hazard_controller_if #(
    parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  id_mdu_start;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_reg_write;
    logic                  branch_taken;
    logic                  halt_req;
    logic                  resume;

    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  mdu_done;
    logic                  halted;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_mdu_start,
        output ex_dest, ex_reg_write, ex_mem_read,
        output mem_dest, mem_reg_write, wb_dest, wb_reg_write,
        output branch_taken, halt_req, resume,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        input  fwd_a, fwd_b, mdu_done, halted
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_mdu_start,
        input  ex_dest, ex_reg_write, ex_mem_read,
        input  mem_dest, mem_reg_write, wb_dest, wb_reg_write,
        input  branch_taken, halt_req, resume,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        output fwd_a, fwd_b, mdu_done, halted
    );

endinterface

// File: rtl/forwarding_unit.sv
// Combinational operand-forwarding select for the EX stage.
// Register r0 is hard-wired to zero and therefore never forwarded.
module forwarding_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_reg_write,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    logic mem_live_s;
    logic wb_live_s;
    logic mem_hit_a_s;
    logic wb_hit_a_s;
    logic mem_hit_b_s;
    logic wb_hit_b_s;

    // Match each source register against the two in-flight producers and pick a select.
    always_comb begin
        mem_live_s  = mem_reg_write && (mem_dest != REG_ZERO);
        wb_live_s   = wb_reg_write && (wb_dest != REG_ZERO);
        mem_hit_a_s = mem_live_s && (mem_dest == id_rs);
        wb_hit_a_s  = wb_live_s && (wb_dest == id_rs);
        mem_hit_b_s = mem_live_s && (mem_dest == id_rt);
        wb_hit_b_s  = wb_live_s && (wb_dest == id_rt);
        fwd_a       = fwd_select(mem_hit_a_s, wb_hit_a_s);
        if (id_uses_rt) begin
            fwd_b = fwd_select(mem_hit_b_s, wb_hit_b_s);
        end else begin
            fwd_b = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing: load-use stall, taken-branch flush, MDU front-end hold, drain and halt.
// Only the FSM state and a 4-bit cycle counter are stored; all control outputs derive from them.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W   = pipeline_pkg::REG_ADDR_W,
    parameter int MDU_CYCLES   = 4,
    parameter int FLUSH_DEPTH  = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    hazard_controller_if.slave hz
);

    localparam logic [3:0] CNT_ZERO   = 4'd0;
    localparam logic [3:0] CNT_ONE    = 4'd1;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);
    localparam logic [3:0] MDU_LOAD   = 4'(MDU_CYCLES - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam bit         FLUSH_MULTI = (FLUSH_DEPTH > 1);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    hc_state_e  state_q;
    hc_state_e  state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    logic       load_use_s;
    logic       last_cnt_s;
    logic       pc_stall_s;
    logic       if_id_stall_s;
    logic       if_id_flush_s;
    logic       id_ex_bubble_s;
    logic       mdu_done_s;
    logic       halted_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       unused_ex_reg_write_s;

    assign unused_ex_reg_write_s = hz.ex_reg_write;

    forwarding_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_forwarding_unit (
        .id_rs         (hz.id_rs),
        .id_rt         (hz.id_rt),
        .id_uses_rt    (hz.id_uses_rt),
        .mem_dest      (hz.mem_dest),
        .mem_reg_write (hz.mem_reg_write),
        .wb_dest       (hz.wb_dest),
        .wb_reg_write  (hz.wb_reg_write),
        .fwd_a         (fwd_a_s),
        .fwd_b         (fwd_b_s)
    );

    // Load-use hazard detection on the instruction currently in ID.
    always_comb begin
        load_use_s = hz.id_valid && hz.ex_mem_read && (hz.ex_dest != REG_ZERO) &&
                     ((hz.ex_dest == hz.id_rs) || (hz.id_uses_rt && (hz.ex_dest == hz.id_rt)));
        last_cnt_s = (cnt_q <= CNT_ONE);
    end

    // Next-state, counter and control-output decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_stall_s     = 1'b0;
        if_id_stall_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        mdu_done_s     = 1'b0;
        halted_s       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.branch_taken) begin
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    if (FLUSH_MULTI) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (load_use_s) begin
                    // One bubble pushes the load to MEM, so the stall never lasts longer.
                    pc_stall_s     = 1'b1;
                    if_id_stall_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                end else if (hz.id_mdu_start && hz.id_valid) begin
                    state_d = ST_MDU_BUSY;
                    cnt_d   = MDU_LOAD;
                end else if (hz.halt_req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if_id_flush_s = 1'b1;
                if (last_cnt_s) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_MDU_BUSY: begin
                pc_stall_s     = 1'b1;
                if_id_stall_s  = 1'b1;
                id_ex_bubble_s = 1'b1;
                if (last_cnt_s) begin
                    mdu_done_s = 1'b1;
                    state_d    = ST_RUN;
                    cnt_d      = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DRAIN: begin
                pc_stall_s     = 1'b1;
                if_id_stall_s  = 1'b1;
                id_ex_bubble_s = 1'b1;
                if (last_cnt_s) begin
                    state_d = ST_HALTED;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HALTED: begin
                halted_s       = 1'b1;
                pc_stall_s     = 1'b1;
                if_id_stall_s  = 1'b1;
                id_ex_bubble_s = 1'b1;
                if (hz.resume) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers; reset discards any pending flush, MDU or drain count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is forced low while reset is held, including the combinational paths.
    assign hz.pc_stall     = reset & pc_stall_s;
    assign hz.if_id_stall  = reset & if_id_stall_s;
    assign hz.if_id_flush  = reset & if_id_flush_s;
    assign hz.id_ex_bubble = reset & id_ex_bubble_s;
    assign hz.mdu_done     = reset & mdu_done_s;
    assign hz.halted       = reset & halted_s;
    assign hz.fwd_a        = reset ? fwd_a_s : FWD_RF;
    assign hz.fwd_b        = reset ? fwd_b_s : FWD_RF;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: expectations are queued as each step is driven
// and compared against the DUT outputs on the following falling edge.
module tb_hazard_controller;

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_STALL = 4'b1101;
    localparam logic [3:0] C_FLBUB = 4'b0011;
    localparam logic [3:0] C_FL    = 4'b0010;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    hazard_controller_if #(.REG_ADDR_W(5)) hz ();

    hazard_controller #(
        .REG_ADDR_W   (5),
        .MDU_CYCLES   (4),
        .FLUSH_DEPTH  (2),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector: {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fwd_a, fwd_b, mdu_done, halted}
    function automatic logic [9:0] mk(input logic [3:0] ctl, input logic [1:0] fa,
                                      input logic [1:0] fb, input logic md, input logic h);
        return {ctl, fa, fb, md, h};
    endfunction

    task automatic clear_inputs();
        hz.id_valid      = 1'b0;
        hz.id_rs         = 5'd0;
        hz.id_rt         = 5'd0;
        hz.id_uses_rt    = 1'b0;
        hz.id_mdu_start  = 1'b0;
        hz.ex_dest       = 5'd0;
        hz.ex_reg_write  = 1'b0;
        hz.ex_mem_read   = 1'b0;
        hz.mem_dest      = 5'd0;
        hz.mem_reg_write = 1'b0;
        hz.wb_dest       = 5'd0;
        hz.wb_reg_write  = 1'b0;
        hz.branch_taken  = 1'b0;
        hz.halt_req      = 1'b0;
        hz.resume        = 1'b0;
    endtask

    // Queue the expectation, compare on the falling edge, then advance one clock.
    task automatic check(input string tag, input logic [9:0] exp_v);
        logic [9:0] obs;
        logic [9:0] want;
        string      t;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(negedge clk);
        obs  = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_bubble,
                hz.fwd_a, hz.fwd_b, hz.mdu_done, hz.halted};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        n_checks++;
        assert (obs === want) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", t, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        clear_inputs();

        // Held reset must mask forwarding and load-use paths.
        hz.id_valid = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_dest = 5'd5; hz.id_rs = 5'd5;
        hz.mem_dest = 5'd5; hz.mem_reg_write = 1'b1;
        check("reset_gate", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        reset = 1'b1;
        clear_inputs();
        check("idle_after_reset", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

        // Forwarding priority and r0 exclusion.
        hz.mem_dest = 5'd3; hz.wb_dest = 5'd3; hz.mem_reg_write = 1'b1; hz.wb_reg_write = 1'b1;
        hz.id_rs = 5'd3;
        check("fwd_a_exmem", mk(C_NONE, 2'b01, 2'b00, 1'b0, 1'b0));
        hz.mem_reg_write = 1'b0;
        check("fwd_a_memwb", mk(C_NONE, 2'b10, 2'b00, 1'b0, 1'b0));
        hz.id_rs = 5'd0;
        check("fwd_a_rs0", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.wb_dest = 5'd0;
        check("fwd_a_r0_never", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.id_rt = 5'd7; hz.id_uses_rt = 1'b1; hz.mem_dest = 5'd7; hz.mem_reg_write = 1'b1;
        hz.wb_dest = 5'd7; hz.wb_reg_write = 1'b1;
        check("fwd_b_exmem", mk(C_NONE, 2'b00, 2'b01, 1'b0, 1'b0));
        hz.mem_reg_write = 1'b0;
        check("fwd_b_memwb", mk(C_NONE, 2'b00, 2'b10, 1'b0, 1'b0));
        hz.id_uses_rt = 1'b0;
        check("fwd_b_no_rt", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        clear_inputs();

        // Load-use on rt: one stall cycle, then the load has moved on.
        hz.id_valid = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_dest = 5'd5; hz.id_rt = 5'd5;
        hz.id_uses_rt = 1'b1; hz.id_rs = 5'd1;
        check("loaduse_rt", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.ex_mem_read = 1'b0;
        check("loaduse_released", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.ex_mem_read = 1'b1; hz.id_uses_rt = 1'b0;
        check("loaduse_rt_unused", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.id_rs = 5'd5;
        check("loaduse_rs", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.ex_dest = 5'd0; hz.id_rs = 5'd0;
        check("loaduse_r0", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        clear_inputs();

        // Branch with a simultaneous load-use: flush wins, FLUSH ignores halt_req.
        hz.id_valid = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_dest = 5'd5; hz.id_rs = 5'd5;
        hz.branch_taken = 1'b1;
        check("branch_first", mk(C_FLBUB, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.branch_taken = 1'b0; hz.halt_req = 1'b1;
        check("branch_second", mk(C_FL, 2'b00, 2'b00, 1'b0, 1'b0));
        clear_inputs();
        check("branch_done", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        check("halt_not_latched", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

        // MDU hold: issue cycle free, then 3 held cycles, done on the last.
        hz.id_valid = 1'b1; hz.id_mdu_start = 1'b1;
        check("mdu_issue", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.id_mdu_start = 1'b0; hz.branch_taken = 1'b1;
        check("mdu_hold1", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.branch_taken = 1'b0;
        check("mdu_hold2", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        check("mdu_hold3_done", mk(C_STALL, 2'b00, 2'b00, 1'b1, 1'b0));
        check("mdu_back_run", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        clear_inputs();

        // Drain, halt, and resume taking precedence over a concurrent halt_req.
        hz.halt_req = 1'b1;
        check("halt_accept", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.halt_req = 1'b0;
        check("drain1", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        check("drain2", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        check("drain3", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        check("halted1", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b1));
        check("halted2", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b1));
        hz.resume = 1'b1; hz.halt_req = 1'b1;
        check("resume_cycle", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b1));
        clear_inputs();
        check("resumed_run", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

        // Asynchronous reset in the middle of an MDU hold.
        hz.id_valid = 1'b1; hz.id_mdu_start = 1'b1;
        check("mdu2_issue", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.id_mdu_start = 1'b0;
        check("mdu2_hold1", mk(C_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        reset = 1'b0;
        hz.mem_dest = 5'd4; hz.mem_reg_write = 1'b1; hz.id_rs = 5'd4;
        check("async_reset_mid_mdu", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        reset = 1'b1;
        clear_inputs();
        check("post_reset_run", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
        check("post_reset_no_residual", mk(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
